// File: rtl/core_sequencer_pkg.sv
// Shared encodings for the multi-cycle RV32I control sequencer: opcodes, FSM states,
// datapath select codes, trap causes and the instruction class enum.
package core_sequencer_pkg;

  localparam logic [6:0] OpLui    = 7'b0110111;
  localparam logic [6:0] OpAuipc  = 7'b0010111;
  localparam logic [6:0] OpJal    = 7'b1101111;
  localparam logic [6:0] OpJalr   = 7'b1100111;
  localparam logic [6:0] OpBranch = 7'b1100011;
  localparam logic [6:0] OpLoad   = 7'b0000011;
  localparam logic [6:0] OpStore  = 7'b0100011;
  localparam logic [6:0] OpOpImm  = 7'b0010011;
  localparam logic [6:0] OpOp     = 7'b0110011;
  localparam logic [6:0] OpFence  = 7'b0001111;
  localparam logic [6:0] OpSystem = 7'b1110011;

  localparam logic [1:0] PcPlus4  = 2'd0;
  localparam logic [1:0] PcTarget = 2'd1;
  localparam logic [1:0] PcJalr   = 2'd2;

  localparam logic [1:0] WbAlu    = 2'd0;
  localparam logic [1:0] WbLoad   = 2'd1;
  localparam logic [1:0] WbPc4    = 2'd2;

  localparam logic [2:0] ImmI = 3'd0;
  localparam logic [2:0] ImmS = 3'd1;
  localparam logic [2:0] ImmB = 3'd2;
  localparam logic [2:0] ImmU = 3'd3;
  localparam logic [2:0] ImmJ = 3'd4;

  localparam logic [1:0] TrapNone    = 2'd0;
  localparam logic [1:0] TrapIllegal = 2'd1;
  localparam logic [1:0] TrapTimeout = 2'd2;

  typedef enum logic [2:0] {
    StFetch, StDecode, StExecute, StMem, StWriteback, StHalt
  } state_e;

  // ClsIllegal is the all-zero value so a cleared class register reads as "nothing decoded".
  typedef enum logic [3:0] {
    ClsIllegal, ClsLui, ClsAuipc, ClsJal, ClsJalr, ClsBranch, ClsLoad, ClsStore,
    ClsOpImm, ClsOp, ClsFence, ClsSystem
  } cls_e;

  function automatic logic is_mem_cls(cls_e c);
    return (c == ClsLoad) || (c == ClsStore);
  endfunction

endpackage

// File: rtl/core_sequencer_if.sv
// Instruction and data memory request/acknowledge handshakes between sequencer and memories.
interface core_sequencer_if;
  logic imem_req;
  logic imem_ack;
  logic dmem_req;
  logic dmem_we;
  logic dmem_ack;

  modport master (output imem_req, output dmem_req, output dmem_we,
                  input imem_ack, input dmem_ack);
  modport slave  (input imem_req, input dmem_req, input dmem_we,
                  output imem_ack, output dmem_ack);
endinterface

// File: rtl/core_sequencer_opcode_classifier.sv
// Combinational opcode decode into instruction class, immediate format and illegal flag.
module core_sequencer_opcode_classifier
  import core_sequencer_pkg::*;
(
  input  logic [6:0] i_opcode,
  output cls_e       o_cls,
  output logic [2:0] o_imm_sel,
  output logic       o_illegal
);

  always_comb begin
    o_cls     = ClsIllegal;
    o_imm_sel = ImmI;
    o_illegal = 1'b0;
    case (i_opcode)
      OpLui:    begin o_cls = ClsLui;    o_imm_sel = ImmU; end
      OpAuipc:  begin o_cls = ClsAuipc;  o_imm_sel = ImmU; end
      OpJal:    begin o_cls = ClsJal;    o_imm_sel = ImmJ; end
      OpJalr:   o_cls = ClsJalr;
      OpBranch: begin o_cls = ClsBranch; o_imm_sel = ImmB; end
      OpLoad:   o_cls = ClsLoad;
      OpStore:  begin o_cls = ClsStore;  o_imm_sel = ImmS; end
      OpOpImm:  o_cls = ClsOpImm;
      OpOp:     o_cls = ClsOp;
      OpFence:  o_cls = ClsFence;
      OpSystem: o_cls = ClsSystem;
      default:  o_illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/core_sequencer.sv
// Multi-cycle fetch/decode/execute/mem/writeback control FSM with memory wait timeout
// and retired-instruction counter.
module core_sequencer
  import core_sequencer_pkg::*;
#(
  parameter int unsigned CNT_W   = 32,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  core_sequencer_if.master mem,
  input  logic [6:0]       i_opcode,
  input  logic             i_branch_taken,
  output logic             o_ir_we,
  output logic             o_pc_we,
  output logic [1:0]       o_pc_sel,
  output logic             o_rf_we,
  output logic [1:0]       o_wb_sel,
  output logic             o_alu_src_a,
  output logic             o_alu_src_b,
  output logic [2:0]       o_imm_sel,
  output logic             o_halted,
  output logic [1:0]       o_trap,
  output logic [CNT_W-1:0] o_instret
);

  localparam logic [7:0] WaitLast = 8'(TIMEOUT - 1);

  state_e           r_state, w_state_next;
  logic [1:0]       r_trap, w_trap_next;
  cls_e             r_cls, w_cls;
  logic [2:0]       r_imm_sel, w_imm_sel;
  logic             w_illegal;
  logic [7:0]       r_wait;
  logic [CNT_W-1:0] r_instret;
  logic             w_req, w_ack, w_expired;

  core_sequencer_opcode_classifier u_classifier (
    .i_opcode  (i_opcode),
    .o_cls     (w_cls),
    .o_imm_sel (w_imm_sel),
    .o_illegal (w_illegal)
  );

  assign w_req     = mem.imem_req | mem.dmem_req;
  assign w_ack     = (r_state == StFetch) ? mem.imem_ack : mem.dmem_ack;
  // An ack in the cycle the counter would reach TIMEOUT takes priority over the trap.
  assign w_expired = (r_wait == WaitLast) && !w_ack;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= StFetch;
      r_trap  <= TrapNone;
    end else begin
      r_state <= w_state_next;
      r_trap  <= w_trap_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_trap_next  = r_trap;
    unique case (r_state)
      StFetch: begin
        if (mem.imem_ack) begin
          w_state_next = StDecode;
        end else if (w_expired) begin
          w_state_next = StHalt;
          w_trap_next  = TrapTimeout;
        end
      end
      StDecode: begin
        if (w_illegal) begin
          w_state_next = StHalt;
          w_trap_next  = TrapIllegal;
        end else if (w_cls == ClsSystem) begin
          w_state_next = StHalt;
        end else begin
          w_state_next = StExecute;
        end
      end
      StExecute:   w_state_next = is_mem_cls(r_cls) ? StMem : StWriteback;
      StMem: begin
        if (mem.dmem_ack) begin
          w_state_next = StWriteback;
        end else if (w_expired) begin
          w_state_next = StHalt;
          w_trap_next  = TrapTimeout;
        end
      end
      StWriteback: w_state_next = StFetch;
      StHalt:      w_state_next = StHalt;
      default:     w_state_next = StHalt;
    endcase
  end

  always_comb begin
    mem.imem_req = 1'b0;
    mem.dmem_req = 1'b0;
    mem.dmem_we  = 1'b0;
    o_ir_we      = 1'b0;
    o_pc_we      = 1'b0;
    o_pc_sel     = PcPlus4;
    o_rf_we      = 1'b0;
    o_wb_sel     = WbAlu;
    o_alu_src_a  = 1'b0;
    o_alu_src_b  = 1'b0;
    o_halted     = 1'b0;
    // Gating on rst_n drops the requests the instant reset asserts.
    if (rst_n) begin
      unique case (r_state)
        StFetch: begin
          mem.imem_req = 1'b1;
          o_ir_we      = mem.imem_ack;
        end
        StExecute: begin
          o_alu_src_a = r_cls inside {ClsAuipc, ClsJal, ClsBranch};
          o_alu_src_b = !(r_cls inside {ClsOp, ClsBranch});
        end
        StMem: begin
          mem.dmem_req = 1'b1;
          mem.dmem_we  = (r_cls == ClsStore);
        end
        StWriteback: begin
          o_pc_we = 1'b1;
          o_rf_we = !(r_cls inside {ClsBranch, ClsStore, ClsFence});
          case (r_cls)
            ClsLoad:         o_wb_sel = WbLoad;
            ClsJal, ClsJalr: o_wb_sel = WbPc4;
            default:         o_wb_sel = WbAlu;
          endcase
          case (r_cls)
            ClsJal:    o_pc_sel = PcTarget;
            ClsJalr:   o_pc_sel = PcJalr;
            ClsBranch: o_pc_sel = i_branch_taken ? PcTarget : PcPlus4;
            default:   o_pc_sel = PcPlus4;
          endcase
        end
        StHalt:  o_halted = 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cls     <= ClsIllegal;
      r_imm_sel <= ImmI;
      r_wait    <= '0;
      r_instret <= '0;
    end else begin
      if (r_state == StDecode) begin
        r_cls     <= w_cls;
        r_imm_sel <= w_imm_sel;
      end
      if (r_state != w_state_next) begin
        r_wait <= '0;
      end else if (w_req && !w_ack) begin
        r_wait <= r_wait + 8'd1;
      end
      if (r_state == StWriteback) begin
        r_instret <= r_instret + 1'b1;
      end
    end
  end

  assign o_imm_sel = r_imm_sel;
  assign o_trap    = r_trap;
  assign o_instret = r_instret;

endmodule

// File: tb/tb_core_sequencer.sv
// Self-checking bench for core_sequencer: per-cycle timeline model of each instruction.
module tb_core_sequencer;

  localparam int unsigned TO = 16;
  localparam int unsigned CW = 4;

  localparam logic [6:0] LUI = 7'h37, AUIPC = 7'h17, JAL = 7'h6F, JALR = 7'h67;
  localparam logic [6:0] BR = 7'h63, LD = 7'h03, ST = 7'h23, OPI = 7'h13;
  localparam logic [6:0] OPR = 7'h33, FEN = 7'h0F, SYS = 7'h73;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  core_sequencer_if bus ();

  logic [6:0]    i_opcode;
  logic          i_branch_taken;
  logic          o_ir_we, o_pc_we, o_rf_we, o_alu_src_a, o_alu_src_b, o_halted;
  logic [1:0]    o_pc_sel, o_wb_sel, o_trap;
  logic [2:0]    o_imm_sel;
  logic [CW-1:0] o_instret;

  int checks = 0;
  int errors = 0;
  logic [CW-1:0] exp_instret;

  core_sequencer #(.CNT_W(CW), .TIMEOUT(TO)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .mem            (bus),
    .i_opcode       (i_opcode),
    .i_branch_taken (i_branch_taken),
    .o_ir_we        (o_ir_we),
    .o_pc_we        (o_pc_we),
    .o_pc_sel       (o_pc_sel),
    .o_rf_we        (o_rf_we),
    .o_wb_sel       (o_wb_sel),
    .o_alu_src_a    (o_alu_src_a),
    .o_alu_src_b    (o_alu_src_b),
    .o_imm_sel      (o_imm_sel),
    .o_halted       (o_halted),
    .o_trap         (o_trap),
    .o_instret      (o_instret)
  );

  function automatic logic [14:0] obs();
    return {bus.imem_req, o_ir_we, bus.dmem_req, bus.dmem_we, o_pc_we, o_rf_we,
            o_pc_sel, o_wb_sel, o_alu_src_a, o_alu_src_b, o_halted, o_trap};
  endfunction

  // Phase: 0 fetch, 1 decode, 2 execute, 3 memory, 4 writeback, 5 halted.
  function automatic logic [14:0] model_vec(input int ph, input logic [6:0] op, input logic tk,
                                            input logic ack, input logic [1:0] tr);
    logic imr = 0, irw = 0, dr = 0, dw = 0, pcw = 0, rfw = 0, a = 0, b = 0, h = 0;
    logic [1:0] ps = 0, ws = 0;
    case (ph)
      0: begin imr = 1; irw = ack; end
      2: begin
        a = (op == AUIPC) || (op == JAL) || (op == BR);
        b = !((op == OPR) || (op == BR));
      end
      3: begin dr = 1; dw = (op == ST); end
      4: begin
        pcw = 1;
        rfw = !((op == BR) || (op == ST) || (op == FEN));
        ws  = (op == LD) ? 2'd1 : ((op == JAL) || (op == JALR)) ? 2'd2 : 2'd0;
        ps  = (op == JAL) ? 2'd1 : (op == JALR) ? 2'd2 : (op == BR && tk) ? 2'd1 : 2'd0;
      end
      5: h = 1;
      default: ;
    endcase
    return {imr, irw, dr, dw, pcw, rfw, ps, ws, a, b, h, tr};
  endfunction

  function automatic logic [2:0] exp_imm(input logic [6:0] op);
    case (op)
      LUI, AUIPC: return 3'd3;
      JAL:        return 3'd4;
      BR:         return 3'd2;
      ST:         return 3'd1;
      default:    return 3'd0;
    endcase
  endfunction

  task automatic chk_cycle(input string nm, input int c, input logic [14:0] want);
    checks++;
    if (obs() !== want) begin
      errors++;
      $display("FAIL %s cyc %0d outputs got %b want %b", nm, c, obs(), want);
    end
    checks++;
    if (o_instret !== exp_instret) begin
      errors++;
      $display("FAIL %s cyc %0d instret got %0d want %0d", nm, c, o_instret, exp_instret);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    bus.imem_ack = 1'b0;
    bus.dmem_ack = 1'b0;
    #1;
    exp_instret = '0;
    chk_cycle("reset", 0, 15'd0);
    checks++;
    if (o_imm_sel !== 3'd0) begin
      errors++;
      $display("FAIL reset imm_sel got %0d want 0", o_imm_sel);
    end
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  // Fetch waits fw cycles, memory waits mw cycles; spurious acks outside their phase.
  task automatic run_instr(input logic [6:0] op, input int fw, input int mw, input logic tk,
                           input string nm);
    bit ls = (op == LD) || (op == ST);
    int total = fw + 4 + (ls ? mw + 1 : 0);
    i_opcode       = op;
    i_branch_taken = tk;
    for (int c = 0; c < total; c++) begin
      int ph;
      if (c <= fw) ph = 0;
      else if (c == fw + 1) ph = 1;
      else if (c == fw + 2) ph = 2;
      else if (ls && c <= fw + 3 + mw) ph = 3;
      else ph = 4;
      @(negedge clk);
      bus.imem_ack = (ph == 0) ? (c == fw) : 1'($urandom_range(0, 1));
      bus.dmem_ack = (ph == 3) ? (c == fw + 3 + mw) : 1'($urandom_range(0, 1));
      #1;
      chk_cycle(nm, c, model_vec(ph, op, tk, c == fw, 2'd0));
      if (ph == 2) begin
        checks++;
        if (o_imm_sel !== exp_imm(op)) begin
          errors++;
          $display("FAIL %s imm_sel got %0d want %0d", nm, o_imm_sel, exp_imm(op));
        end
      end
    end
    exp_instret = exp_instret + 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
  endtask

  task automatic test_directed();
    run_instr(OPI, 0, 0, 1'b0, "addi");
    run_instr(LD, 0, 3, 1'b0, "lw_wait3");
    run_instr(BR, 0, 0, 1'b1, "beq_taken");
    run_instr(BR, 1, 0, 1'b0, "beq_not");
    run_instr(JALR, 0, 0, 1'b0, "jalr");
    run_instr(ST, 2, 0, 1'b1, "sw");
    run_instr(JAL, 0, 0, 1'b0, "jal");
    run_instr(LUI, 0, 0, 1'b0, "lui");
    run_instr(FEN, 0, 0, 1'b0, "fence");
  endtask

  task automatic test_ack_wins();
    run_instr(OPI, TO - 1, 0, 1'b0, "fetch_ack_last");
    run_instr(LD, 0, TO - 1, 1'b0, "mem_ack_last");
    run_instr(ST, TO - 1, TO - 1, 1'b0, "both_ack_last");
  endtask

  task automatic test_random();
    logic [6:0] ops [10] = '{LUI, AUIPC, JAL, JALR, BR, LD, ST, OPI, OPR, FEN};
    for (int n = 0; n < 40; n++) begin
      run_instr(ops[$urandom_range(0, 9)], $urandom_range(0, 3), $urandom_range(0, 3),
                1'($urandom_range(0, 1)), "random");
    end
  endtask

  task automatic test_halt(input logic [6:0] op, input logic [1:0] tr, input string nm);
    i_opcode = op;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      bus.imem_ack = (c == 0) ? 1'b1 : 1'($urandom_range(0, 1));
      bus.dmem_ack = 1'($urandom_range(0, 1));
      #1;
      chk_cycle(nm, c, model_vec((c < 2) ? c : 5, op, 1'b0, 1'b1, (c < 2) ? 2'd0 : tr));
    end
    do_reset();
  endtask

  task automatic test_timeout(input bit in_mem, input string nm);
    int base = in_mem ? 3 : 0;
    i_opcode = LD;
    for (int c = 0; c < base + TO + 4; c++) begin
      int ph;
      if (c < base) ph = c;
      else if (c < base + TO) ph = in_mem ? 3 : 0;
      else ph = 5;
      @(negedge clk);
      bus.imem_ack = (in_mem && c == 0) ? 1'b1 : (ph == 5) ? 1'($urandom_range(0, 1)) : 1'b0;
      bus.dmem_ack = (ph == 5) ? 1'($urandom_range(0, 1)) : 1'b0;
      #1;
      chk_cycle(nm, c, model_vec(ph, LD, 1'b0, in_mem && c == 0, (ph == 5) ? 2'd2 : 2'd0));
    end
    do_reset();
  endtask

  task automatic test_reset_mid_mem();
    run_instr(OPI, 0, 0, 1'b0, "pre_mem_addi");
    i_opcode = LD;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      bus.imem_ack = (c == 0);
      bus.dmem_ack = 1'b0;
    end
    #1;
    chk_cycle("mid_mem_before", 3, model_vec(3, LD, 1'b0, 1'b0, 2'd0));
    #1 rst_n = 1'b0;
    #1;
    exp_instret = '0;
    chk_cycle("mid_mem_reset", 3, 15'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    run_instr(OPI, 0, 0, 1'b0, "post_reset_addi");
  endtask

  initial begin
    rst_n          = 1'b1;
    i_opcode       = OPI;
    i_branch_taken = 1'b0;
    bus.imem_ack   = 1'b0;
    bus.dmem_ack   = 1'b0;
    #2;
    test_reset();
    test_directed();
    test_ack_wins();
    test_random();
    test_halt(7'h7F, 2'd1, "illegal");
    test_halt(SYS, 2'd0, "ecall");
    test_timeout(1'b0, "fetch_timeout");
    test_timeout(1'b1, "mem_timeout");
    test_reset_mid_mem();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
